// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin scheduler sharing one UART transmitter between byte sources
module uart_tx_scheduler #(
    parameter int N_REQ       = 3,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*DATA_W-1:0]   data_i,
    input  logic [N_REQ-1:0]          lock_i,
    output logic [N_REQ-1:0]          ack_o,
    output logic [N_REQ-1:0]          grant_o,
    output logic [DATA_W-1:0]         uart_tx_data_o,
    output logic                      uart_tx_start_o,
    input  logic                      uart_tx_done_i,
    output logic                      busy_o,
    output logic                      timeout_o
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit WDOG_EN = (TIMEOUT_CYC > 0);
    // Abort is taken in the WAIT_DONE cycle whose increment brings the timer to TIMEOUT_CYC.
    localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_HOLD    = 3'd4;

    logic [2:0]        state;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     owner;
    logic [N_REQ-1:0]  grant_q;
    logic [DATA_W-1:0] data_q;
    logic [TW-1:0]     timer;

    logic              win_valid;
    logic [IW-1:0]     win_idx;
    logic [N_REQ-1:0]  win_onehot;
    logic [IW-1:0]     owner_next;
    logic [DATA_W-1:0] win_data;
    logic [DATA_W-1:0] owner_data;
    logic              wd_hit;

    // Round-robin pick: first requesting index scanning upward from the pointer, wrapping.
    always_comb begin
        int k;
        win_valid = 1'b0;
        win_idx   = '0;
        k         = 0;
        for (int i = 0; i < N_REQ; i++) begin
            k = int'(ptr) + i;
            if (k >= N_REQ) begin
                k = k - N_REQ;
            end
            if (!win_valid && req_i[k]) begin
                win_valid = 1'b1;
                win_idx   = IW'(k);
            end
        end
    end

    // One-hot form of the winner, used to load the grant register.
    always_comb begin
        win_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            win_onehot[i] = win_valid && (win_idx == IW'(i));
        end
    end

    assign owner_next = (owner == IW'(N_REQ - 1)) ? '0 : owner + IW'(1);
    assign win_data   = data_i[win_idx*DATA_W +: DATA_W];
    assign owner_data = data_i[owner*DATA_W +: DATA_W];
    assign wd_hit     = WDOG_EN && (timer == TIMER_LAST);

    // Transfer FSM: arbitrate, strobe start, wait for done or watchdog, then release or hold for a burst.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= S_IDLE;
            ptr     <= '0;
            owner   <= '0;
            grant_q <= '0;
            data_q  <= '0;
            timer   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_valid) begin
                        owner   <= win_idx;
                        grant_q <= win_onehot;
                        data_q  <= win_data;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (timer != {TW{1'b1}}) begin
                        timer <= timer + TW'(1);
                    end
                    if (wd_hit) begin
                        grant_q <= '0;
                        ptr     <= owner_next;
                        state   <= S_IDLE;
                    end else if (uart_tx_done_i) begin
                        state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (lock_i[owner]) begin
                        state <= S_HOLD;
                    end else begin
                        grant_q <= '0;
                        ptr     <= owner_next;
                        state   <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (!lock_i[owner]) begin
                        grant_q <= '0;
                        ptr     <= owner_next;
                        state   <= S_IDLE;
                    end else if (req_i[owner]) begin
                        data_q <= owner_data;
                        state  <= S_START;
                    end
                end
                default: begin
                    grant_q <= '0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    assign grant_o         = grant_q;
    assign ack_o           = (state == S_RELEASE) ? grant_q : '0;
    assign uart_tx_data_o  = data_q;
    assign uart_tx_start_o = (state == S_START);
    assign busy_o          = (state != S_IDLE);
    assign timeout_o       = (state == S_WAIT) && wd_hit;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - scoreboard bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [23:0] data;
    logic [2:0]  lock;
    logic [2:0]  ack;
    logic [2:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;
    logic        busy;
    logic        tmo;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;
    int   done_lat = 4;
    bit   done_auto = 1'b1;
    bit   auto_drop = 1'b1;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .N_REQ       (3),
        .DATA_W      (8),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_i           (req),
        .data_i          (data),
        .lock_i          (lock),
        .ack_o           (ack),
        .grant_o         (grant),
        .uart_tx_data_o  (tx_data),
        .uart_tx_start_o (tx_start),
        .uart_tx_done_i  (tx_done),
        .busy_o          (busy),
        .timeout_o       (tmo)
    );

    task automatic step();
        @(posedge clk);
        #1;
        tx_done = 1'b0;
        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) tx_done = 1'b1;
        end
        if (tx_start && done_auto) done_cnt = done_lat;
        if (auto_drop) req = req & ~ack;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        req      = '0;
        lock     = '0;
        data     = '0;
        tx_done  = 1'b0;
        done_cnt = 0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bit saw_start = 0, bad_grant = 0, bad_busy = 0;
        rst_n = 1'b0; req = '0; lock = '0; data = '0; tx_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ack, grant, tx_data, tx_start, busy, tmo} !== 17'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {ack, grant, tx_data, tx_start, busy, tmo});
        end
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (tx_start) saw_start = 1;
            if (grant !== 3'b000) bad_grant = 1;
            if (busy !== 1'b0) bad_busy = 1;
        end
        checks++;
        if (saw_start) begin errors++; $display("FAIL idle_start: got 1 expected 0"); end
        checks++;
        if (bad_grant) begin errors++; $display("FAIL idle_grant: got nonzero expected 0"); end
        checks++;
        if (bad_busy) begin errors++; $display("FAIL idle_busy: got 1 expected 0"); end
    endtask

    task automatic test_single();
        int s = 0;
        bit got_ack = 0;
        logic [2:0] eoh;
        do_reset();
        auto_drop = 1; done_auto = 1; done_lat = 4;
        data[7:0] = 8'h1C;
        sb.push_back('{idx: 0, data: 8'h1C});
        req = 3'b001;
        step();
        checks++;
        if (tx_start !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: start=%b expected 1 one clock after req sampled", tx_start);
        end else begin
            cur = sb.pop_front();
            eoh = 3'b001 << cur.idx;
            checks++;
            if (tx_data !== cur.data || grant !== eoh) begin
                errors++;
                $display("FAIL single_byte: got data %h grant %b expected %h %b", tx_data, grant, cur.data, eoh);
            end
        end
        for (int c = 1; c <= 20 && !got_ack; c++) begin
            step();
            if (ack !== 3'b000) begin
                got_ack = 1;
                s = c;
                checks++;
                if (ack !== 3'b001) begin errors++; $display("FAIL single_ack: got %b expected 001", ack); end
            end
        end
        checks++;
        if (s != 5) begin errors++; $display("FAIL single_ack_time: got %0d expected 5 cycles after start", s); end
        step();
        checks++;
        if (grant !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_release: got grant %b busy %b expected 000 0", grant, busy);
        end
    endtask

    task automatic test_round_robin();
        int nst = 0, nack = 0;
        logic [2:0] eoh;
        do_reset();
        auto_drop = 0; done_auto = 1; done_lat = 3;
        data = {8'hC2, 8'hB1, 8'hA0};
        sb.push_back('{idx: 0, data: 8'hA0});
        sb.push_back('{idx: 1, data: 8'hB1});
        sb.push_back('{idx: 2, data: 8'hC2});
        sb.push_back('{idx: 0, data: 8'hA0});
        req = 3'b111;
        for (int c = 0; c < 300 && nack < 4; c++) begin
            step();
            if (tx_start) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rr_extra_start: got data %h expected no start", tx_data);
                end else begin
                    cur = sb.pop_front();
                    eoh = 3'b001 << cur.idx;
                    if (tx_data !== cur.data || grant !== eoh) begin
                        errors++;
                        $display("FAIL rr_byte: got data %h grant %b expected %h %b", tx_data, grant, cur.data, eoh);
                    end
                end
                nst++;
                if (nst == 4) req = 3'b000;
            end
            if (ack !== 3'b000) begin
                eoh = 3'b001 << cur.idx;
                checks++;
                if (ack !== eoh) begin errors++; $display("FAIL rr_ack: got %b expected %b", ack, eoh); end
                nack++;
            end
        end
        checks++;
        if (nack != 4 || sb.size() != 0) begin
            errors++;
            $display("FAIL rr_complete: got %0d acks %0d pending expected 4 0", nack, sb.size());
        end
    endtask

    task automatic test_burst_lock();
        int nack = 0, nb = 0, ns2 = 0, c = 0;
        int st[3];
        logic [2:0] eoh;
        do_reset();
        auto_drop = 0; done_auto = 1; done_lat = 4;
        data[23:16] = 8'hD0;
        lock = 3'b100;
        sb.push_back('{idx: 2, data: 8'hD0});
        sb.push_back('{idx: 2, data: 8'hD1});
        sb.push_back('{idx: 2, data: 8'hD2});
        sb.push_back('{idx: 0, data: 8'h55});
        req = 3'b100;
        for (c = 0; c < 300 && nack < 4; c++) begin
            step();
            if (tx_start) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL burst_extra_start: got data %h expected no start", tx_data);
                end else begin
                    cur = sb.pop_front();
                    eoh = 3'b001 << cur.idx;
                    if (tx_data !== cur.data || grant !== eoh) begin
                        errors++;
                        $display("FAIL burst_byte: got data %h grant %b expected %h %b", tx_data, grant, cur.data, eoh);
                    end
                    if (cur.idx == 2 && ns2 < 3) begin
                        st[ns2] = c;
                        ns2++;
                    end
                    if (ns2 == 1 && cur.idx == 2) begin
                        data[7:0] = 8'h55;
                        req[0] = 1'b1;
                    end
                end
            end
            if (ack !== 3'b000) begin
                eoh = 3'b001 << cur.idx;
                checks++;
                if (ack !== eoh) begin errors++; $display("FAIL burst_ack: got %b expected %b", ack, eoh); end
                nack++;
                if (cur.idx == 2) begin
                    nb++;
                    if (nb < 3) data[23:16] = 8'hD0 + 8'(nb);
                    else begin lock[2] = 1'b0; req[2] = 1'b0; end
                end else begin
                    req[0] = 1'b0;
                end
            end
        end
        checks++;
        if (nack != 4 || ns2 != 3) begin
            errors++;
            $display("FAIL burst_complete: got %0d acks %0d burst starts expected 4 3", nack, ns2);
        end else begin
            checks++;
            if (st[1] - st[0] != 7 || st[2] - st[1] != 7) begin
                errors++;
                $display("FAIL burst_gap: got %0d %0d expected 7 7", st[1] - st[0], st[2] - st[1]);
            end
        end
    endtask

    task automatic test_timeout();
        int nack = 0, ntmo = 0, s0 = -1, tmo_at = -1;
        bit ack_early = 0;
        logic [2:0] eoh;
        do_reset();
        auto_drop = 1; done_auto = 0; done_lat = 4;
        data[15:8]  = 8'h77;
        data[23:16] = 8'h88;
        sb.push_back('{idx: 1, data: 8'h77});
        sb.push_back('{idx: 2, data: 8'h88});
        sb.push_back('{idx: 1, data: 8'h77});
        req = 3'b110;
        for (int c = 0; c < 300 && nack < 2; c++) begin
            step();
            if (tx_start) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL to_extra_start: got data %h expected no start", tx_data);
                end else begin
                    cur = sb.pop_front();
                    eoh = 3'b001 << cur.idx;
                    if (tx_data !== cur.data || grant !== eoh) begin
                        errors++;
                        $display("FAIL to_byte: got data %h grant %b expected %h %b", tx_data, grant, cur.data, eoh);
                    end
                end
                if (s0 < 0) s0 = c;
            end
            if (tmo) begin
                ntmo++;
                if (tmo_at < 0) tmo_at = c - s0;
                done_auto = 1;
            end
            if (ack !== 3'b000) begin
                if (ntmo == 0) ack_early = 1;
                eoh = 3'b001 << cur.idx;
                checks++;
                if (ack !== eoh) begin errors++; $display("FAIL to_ack: got %b expected %b", ack, eoh); end
                nack++;
            end
        end
        checks++;
        if (tmo_at != 16) begin errors++; $display("FAIL to_time: got %0d expected 16 cycles after start", tmo_at); end
        checks++;
        if (ntmo != 1) begin errors++; $display("FAIL to_pulses: got %0d expected 1", ntmo); end
        checks++;
        if (ack_early) begin errors++; $display("FAIL to_no_ack: got ack before timeout expected none"); end
        checks++;
        if (nack != 2 || sb.size() != 0) begin
            errors++;
            $display("FAIL to_complete: got %0d acks %0d pending expected 2 0", nack, sb.size());
        end
    endtask

    task automatic test_spurious_and_reset();
        bit got_ack = 0;
        logic [2:0] eoh;
        do_reset();
        auto_drop = 1; done_auto = 0;
        step();
        tx_done = 1'b1;
        step();
        checks++;
        if (ack !== 3'b000 || busy !== 1'b0 || grant !== 3'b000 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL idle_done: got ack %b busy %b grant %b start %b expected all 0", ack, busy, grant, tx_start);
        end
        data[7:0] = 8'h3C;
        req = 3'b001;
        step();
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h3C) begin
            errors++;
            $display("FAIL abort_start: got start %b data %h expected 1 3c", tx_start, tx_data);
        end
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ack, grant, tx_data, tx_start, busy, tmo} !== 17'h0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0", {ack, grant, tx_data, tx_start, busy, tmo});
        end
        req = 3'b000;
        tx_done = 1'b1;
        step();
        rst_n = 1'b1;
        tx_done = 1'b1;
        step();
        step();
        checks++;
        if (ack !== 3'b000 || busy !== 1'b0 || grant !== 3'b000 || tmo !== 1'b0) begin
            errors++;
            $display("FAIL late_done: got ack %b busy %b grant %b expected 000 0 000", ack, busy, grant);
        end
        done_auto = 1; done_lat = 2;
        data[15:8] = 8'h5A;
        sb.push_back('{idx: 1, data: 8'h5A});
        req = 3'b010;
        for (int c = 0; c < 40 && !got_ack; c++) begin
            step();
            if (tx_start) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL post_extra_start: got data %h expected no start", tx_data);
                end else begin
                    cur = sb.pop_front();
                    eoh = 3'b001 << cur.idx;
                    if (tx_data !== cur.data || grant !== eoh) begin
                        errors++;
                        $display("FAIL post_byte: got data %h grant %b expected %h %b", tx_data, grant, cur.data, eoh);
                    end
                end
            end
            if (ack !== 3'b000) begin
                got_ack = 1;
                checks++;
                if (ack !== 3'b010) begin errors++; $display("FAIL post_ack: got %b expected 010", ack); end
            end
        end
        checks++;
        if (!got_ack || sb.size() != 0) begin
            errors++;
            $display("FAIL post_complete: got ack %b pending %0d expected 1 0", got_ack, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_burst_lock();
        test_timeout();
        test_spurious_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
